// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
//   Bus between the CPU store path and the buffered UART transmitter.
//   master : CPU side, drives the push and flag-clear requests.
//   slave  : transmitter side, returns FIFO status, overflow flag and the line.
//   Signals:
//     wr_en       push request, one byte per cycle it is high
//     wr_data     byte to push
//     clr_ovf     clears the sticky overflow flag
//     tx_full     FIFO holds FIFO_DEPTH bytes
//     tx_empty    FIFO empty
//     tx_busy     a frame is on the line
//     ovf         sticky: a push was dropped because the FIFO was full
//     PC_Uart_txd serial line, idle high
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       ovf;
    logic       PC_Uart_txd;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  tx_full, tx_empty, tx_busy, ovf, PC_Uart_txd
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output tx_full, tx_empty, tx_busy, ovf, PC_Uart_txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes pushed over the bus are queued in a
//   small FIFO and serialised LSB first on PC_Uart_txd; bit timing comes from
//   an internal divider of sysclk.
//   Ports:
//     sysclk  system clock, rising edge
//     reset   synchronous, active-low reset
//     bus     uart_tx_fifo_if.slave (push/clear in, status and line out)
//   Parameters:
//     BAUD_DIV   sysclk cycles per serial bit (2..65535)
//     FIFO_DEPTH byte entries in the buffer (power of two, 2..16)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int BAUD_DIV   = 10416,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           sysclk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_txd, r_busy, r_ovf;

    logic w_full, w_empty, w_push, w_drop, w_pop, w_bit_end;
    logic w_txd_nxt, w_busy_nxt, w_shift_en, w_bit_inc, w_baud_clr;

    assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_bit_end = (r_baud == 16'(BAUD_DIV - 1));
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted; it lands in the entry being read out this edge.
    assign w_push    = bus.wr_en && (!w_full || w_pop);
    assign w_drop    = bus.wr_en && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_txd_nxt   = r_txd;
        w_busy_nxt  = r_busy;
        w_shift_en  = 1'b0;
        w_bit_inc   = 1'b0;
        w_baud_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_txd_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_baud_clr  = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_txd_nxt   = r_shift[0];
                    w_baud_clr  = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_clr = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        // next bit is what shift[0] becomes after the shift
                        w_txd_nxt  = r_shift[1];
                        w_shift_en = 1'b1;
                        w_bit_inc  = 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_clr = 1'b1;
                    if (!w_empty) begin
                        // chain straight into the next start bit, no idle gap
                        w_pop       = 1'b1;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = START;
                    end else begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FIFO storage carries no reset; only pointers and count define validity.
    always_ff @(posedge sysclk) begin
        if (w_push) r_mem[r_wptr] <= bus.wr_data;
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;

            if (w_baud_clr || r_state == IDLE) r_baud <= '0;
            else                               r_baud <= r_baud + 16'd1;

            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) begin
                r_shift <= r_mem[r_rptr];
                r_rptr  <= r_rptr + PW'(1);
                r_bit   <= '0;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bit_inc) r_bit <= r_bit + 3'd1;

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase

            // a drop in the same cycle as a clear keeps the flag set
            if (w_drop)           r_ovf <= 1'b1;
            else if (bus.clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign bus.tx_full     = w_full;
    assign bus.tx_empty    = w_empty;
    assign bus.tx_busy     = r_busy;
    assign bus.ovf         = r_ovf;
    assign bus.PC_Uart_txd = r_txd;
endmodule
